mvm_out_collector: RTL and testbench
====================================

MVM_OUT_COLLECTOR -- requirements
Module: mvm_out_collector

Interface
REQ-001 Parameter MAT_SCALE, default 4: result words per frame (one y vector).
REQ-002 Parameter IN_WIDTH, default 16: width of signed result words from the matrix-vector multiplier.
REQ-003 Parameter OUT_WIDTH, default 8: width of signed output words; OUT_WIDTH <= IN_WIDTH.
REQ-004 Parameter DEPTH, default 8: buffer depth in words, a power of 2 and >= MAT_SCALE.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port done_in, input, 1: one-cycle frame-start pulse from the multiplier.
REQ-008 Port data_in, input, IN_WIDTH, signed: result word; y[0] arrives in the done_in cycle, y[k] arrives k cycles later.
REQ-009 Port out_valid, output, 1: out_data and out_row hold a valid word.
REQ-010 Port out_ready, input, 1: consumer accepts the word.
REQ-011 Port out_data, output, OUT_WIDTH, signed: head word of the buffer.
REQ-012 Port out_row, output, $clog2(MAT_SCALE): row index of the head word.
REQ-013 Port busy, output, 1: high while a frame capture is in progress.
REQ-014 Port overflow, output, 1: sticky flag, a word was dropped because the buffer was full.
REQ-015 Port frame_err, output, 1: sticky flag, done_in arrived during a capture.
REQ-016 Port clr_err, input, 1: synchronously clears overflow and frame_err.

Function
REQ-017 FSM states: IDLE and CAP.
- IDLE -> CAP on done_in.
- CAP -> IDLE in the cycle the row counter equals MAT_SCALE-1.
REQ-018 The row counter is loaded with 0 on the done_in cycle and increments each CAP cycle; it never wraps within a frame.
REQ-019 Capture:
- The done_in cycle in IDLE captures data_in as row 0.
- Each following CAP cycle captures the next row.
- Exactly MAT_SCALE words are captured per frame, one per cycle, with no gaps.
REQ-020 done_in while in CAP is ignored for capture, sets frame_err, and does not restart the counter.
REQ-021 Buffer: FIFO of DEPTH entries {word, row}; push = capture cycle, pop = out_valid and out_ready.
REQ-022 Latency: a word captured in cycle T appears on out_data no earlier than cycle T+1.
- If the FIFO was empty with no pop pending, out_valid rises at T+1.
REQ-023 out_data and out_row hold stable while out_valid is high and out_ready is low.
REQ-024 Full with no pop in the same cycle: the pushed word is dropped, overflow is set, and the row counter still advances.
REQ-025 Full with a pop in the same cycle: the push is accepted and the occupancy stays at DEPTH.
REQ-026 Empty with a push in the same cycle: out_valid is low in that cycle; the word is not bypassed combinationally.
REQ-027 Read and write pointers wrap modulo DEPTH; a separate occupancy count, range 0..DEPTH, distinguishes full from empty.
REQ-028 busy is 1 in CAP and 0 otherwise.
REQ-029 clr_err and a same-cycle set event together: the set wins.

Reset
REQ-030 reset has priority over all other inputs.
REQ-031 On reset:
- State goes to IDLE and the row counter to 0.
- The FIFO empties.
- out_valid, busy, overflow and frame_err go to 0; out_data and out_row go to 0.
REQ-032 Reset during CAP abandons the frame; words already buffered are discarded.

Configuration
REQ-033 Macro MVM_COLLECT_SAT_EN, when defined: each captured word is saturated to the signed OUT_WIDTH range before buffering; values above the maximum map to the maximum and values below the minimum map to the minimum.
REQ-034 Macro MVM_COLLECT_SAT_EN, when not defined: each captured word is truncated to its low OUT_WIDTH bits.
REQ-035 The interface and timing are identical with and without MVM_COLLECT_SAT_EN.

Verification (defaults)
REQ-036 Scenario: done_in with data_in 5,-3,100,0 on consecutive cycles, out_ready=1 -> out_data 5,-3,100,0 with out_row 0..3, first word one cycle after done_in.
REQ-037 Scenario: data_in 300 and -200 -> out_data 127 and -128 with MVM_COLLECT_SAT_EN; 44 and 56 without it.
REQ-038 Scenario: out_ready=0, three frames -> 8 words buffered, 4 dropped, overflow=1; after draining, rows 0..3 then 0..3; clr_err then clears overflow.
REQ-039 Scenario: done_in again 2 cycles into a frame -> frame_err=1, exactly 4 words captured, busy low after 4 cycles.
REQ-040 Scenario: reset asserted in the third capture cycle -> out_valid=0 next cycle, FIFO empty, and a following frame is captured normally.
REQ-041 Scenario: FIFO full, out_ready=1 during a frame -> no drop, overflow stays 0, output order preserved.

Source files
------------

// File: rtl/mvm_out_collector.sv
// Collects one MAT_SCALE-word result frame per done_in pulse into a {word,row} FIFO.
// Optional macro MVM_COLLECT_SAT_EN saturates captured words instead of truncating.
module mvm_out_collector #(
  parameter int unsigned MAT_SCALE = 4,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned DEPTH     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               done_in,
  input  logic signed [IN_WIDTH-1:0]         data_in,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic signed [OUT_WIDTH-1:0]        out_data,
  output logic [$clog2(MAT_SCALE)-1:0]       out_row,
  output logic                               busy,
  output logic                               overflow,
  output logic                               frame_err,
  input  logic                               clr_err
);

  localparam int unsigned ROW_W = $clog2(MAT_SCALE);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = OUT_WIDTH + ROW_W;

  typedef enum logic {
    IDLE = 1'b0,
    CAP  = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [ROW_W-1:0]    row_cnt, row_cnt_nxt;
  logic [ROW_W-1:0]    cap_row_c;
  logic                cap_c;
  logic                frame_err_set_c;

  logic signed [OUT_WIDTH-1:0] cap_word_c;
  logic [ENT_W-1:0]    new_ent_c;
  logic [ENT_W-1:0]    head_nxt_c;

  logic [ENT_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt_c;
  logic [CNT_W-1:0]    count, count_nxt_c;
  logic                full_c, pop_c, push_c, drop_c;

  // Frame sequencing: row 0 in the done_in cycle, then rows 1..MAT_SCALE-1 in CAP
  always_comb begin
    state_nxt       = state;
    row_cnt_nxt     = row_cnt;
    cap_c           = 1'b0;
    cap_row_c       = '0;
    frame_err_set_c = 1'b0;
    case (state)
      IDLE: begin
        if (done_in) begin
          cap_c       = 1'b1;
          cap_row_c   = '0;
          state_nxt   = CAP;
          row_cnt_nxt = ROW_W'(1);
        end
      end
      CAP: begin
        cap_c           = 1'b1;
        cap_row_c       = row_cnt;
        frame_err_set_c = done_in;
        if (row_cnt == ROW_W'(MAT_SCALE - 1)) begin
          state_nxt   = IDLE;
          row_cnt_nxt = '0;
        end else begin
          row_cnt_nxt = row_cnt + ROW_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        row_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      row_cnt <= '0;
    end else begin
      state   <= state_nxt;
      row_cnt <= row_cnt_nxt;
    end
  end

`ifdef MVM_COLLECT_SAT_EN
  localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
    IN_WIDTH'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [IN_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    cap_word_c = OUT_WIDTH'(data_in);
    if (data_in > SAT_MAX) begin
      cap_word_c = OUT_WIDTH'(SAT_MAX);
    end else if (data_in < SAT_MIN) begin
      cap_word_c = OUT_WIDTH'(SAT_MIN);
    end
  end
`else
  assign cap_word_c = OUT_WIDTH'(data_in);
`endif

  // FIFO control; a full FIFO still accepts a push when the head pops in the same cycle
  always_comb begin
    full_c       = (count == CNT_W'(DEPTH));
    pop_c        = out_valid & out_ready;
    push_c       = cap_c & (~full_c | pop_c);
    drop_c       = cap_c & full_c & ~pop_c;
    new_ent_c    = {cap_word_c, cap_row_c};
    rd_ptr_nxt_c = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_nxt_c  = count;
    case ({push_c, pop_c})
      2'b10:   count_nxt_c = count + CNT_W'(1);
      2'b01:   count_nxt_c = count - CNT_W'(1);
      default: count_nxt_c = count;
    endcase
    // The new head is the word being written when it lands at the next read slot
    head_nxt_c = (push_c && (wr_ptr == rd_ptr_nxt_c)) ? new_ent_c : mem[rd_ptr_nxt_c];
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= new_ent_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr    <= rd_ptr_nxt_c;
      count     <= count_nxt_c;
      out_valid <= (count_nxt_c != '0);
      if (count_nxt_c != '0) begin
        out_data <= head_nxt_c[ENT_W-1:ROW_W];
        out_row  <= head_nxt_c[ROW_W-1:0];
      end
    end
  end

  // Sticky error flags; a set event in the same cycle beats clr_err
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      busy      <= (state_nxt == CAP);
      overflow  <= drop_c | (overflow & ~clr_err);
      frame_err <= frame_err_set_c | (frame_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_mvm_out_collector.sv
// Randomized self-checking bench for mvm_out_collector against a queue-based frame model.
module tb_mvm_out_collector;

  localparam int MS = 4;
  localparam int IW = 16;
  localparam int OW = 8;
  localparam int DP = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 done_in = 1'b0;
  logic signed [IW-1:0] data_in = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic signed [OW-1:0] out_data;
  logic [1:0]           out_row;
  logic                 busy;
  logic                 overflow;
  logic                 frame_err;
  logic                 clr_err = 1'b0;

  mvm_out_collector #(
    .MAT_SCALE(MS), .IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DP)
  ) dut (
    .clk(clk), .reset(reset), .done_in(done_in), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .busy(busy), .overflow(overflow),
    .frame_err(frame_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int r;
  } ent_t;

  ent_t q[$];
  int   m_left;
  int   m_row;
  bit   m_ov;
  bit   m_fe;
  int   n_tests;
  int   n_fail;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Word as it should appear at the output after width reduction
  function automatic int conv(input int x);
    int hi;
    int v;
    hi = (1 << (OW - 1)) - 1;
`ifdef MVM_COLLECT_SAT_EN
    v = x;
    if (x > hi) v = hi;
    if (x < -hi - 1) v = -hi - 1;
`else
    v = x & ((1 << OW) - 1);
    if (v > hi) v = v - (1 << OW);
`endif
    return v;
  endfunction

  // One clock: apply inputs, advance the model, then compare every output
  task automatic cycle(input bit d, input int x, input bit rdy, input bit clr, input bit rs);
    bit   cap;
    bit   pop;
    bit   drop;
    bit   fe_set;
    int   row;
    int   presize;
    ent_t e;
    done_in   = d;
    data_in   = IW'(x);
    out_ready = rdy;
    clr_err   = clr;
    reset     = rs;
    if (rs) begin
      q.delete();
      m_left = 0;
      m_row  = 0;
      m_ov   = 0;
      m_fe   = 0;
    end else begin
      cap = 0; drop = 0; fe_set = 0; row = 0;
      if (m_left == 0) begin
        if (d) begin
          cap = 1; row = 0; m_left = MS - 1; m_row = 1;
        end
      end else begin
        cap = 1; row = m_row; m_row++; m_left--;
        fe_set = d;
      end
      presize = q.size();
      pop = (presize > 0) && rdy;
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (presize < DP || pop) begin
          e.w = conv(x);
          e.r = row;
          q.push_back(e);
        end else begin
          drop = 1;
        end
      end
      m_ov = drop | (m_ov & !clr);
      m_fe = fe_set | (m_fe & !clr);
    end
    @(posedge clk);
    #1;
    check("valid", int'(out_valid), int'(q.size() != 0));
    if (q.size() != 0) begin
      check("data", int'(out_data), q[0].w);
      check("row", int'(out_row), q[0].r);
    end
    check("busy", int'(busy), int'(m_left > 0));
    check("overflow", int'(overflow), int'(m_ov));
    check("frame_err", int'(frame_err), int'(m_fe));
  endtask

  task automatic frame(input int a, input int b, input int c, input int d4, input bit rdy);
    cycle(1, a, rdy, 0, 0);
    cycle(0, b, rdy, 0, 0);
    cycle(0, c, rdy, 0, 0);
    cycle(0, d4, rdy, 0, 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_left  = 0;
    m_row   = 0;
    m_ov    = 0;
    m_fe    = 0;

    // Reset state
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check("rst_data", int'(out_data), 0);
    check("rst_row", int'(out_row), 0);

    // Basic frame, first word one cycle after done_in
    cycle(1, 5, 1, 0, 0);
    check("first_word", int'(out_data), 5);
    cycle(0, -3, 1, 0, 0);
    cycle(0, 100, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    check("row3", int'(out_row), 3);
    cycle(0, 0, 1, 0, 0);

    // Width reduction
    cycle(1, 300, 1, 0, 0);
`ifdef MVM_COLLECT_SAT_EN
    check("conv_hi", int'(out_data), 127);
`else
    check("conv_hi", int'(out_data), 44);
`endif
    cycle(0, -200, 1, 0, 0);
`ifdef MVM_COLLECT_SAT_EN
    check("conv_lo", int'(out_data), -128);
`else
    check("conv_lo", int'(out_data), 56);
`endif
    cycle(0, 7, 1, 0, 0);
    cycle(0, -7, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);

    // Three frames with no consumer: overflow, then drain and clear
    for (int f = 0; f < 3; f++) frame(10 * f + 1, 10 * f + 2, 10 * f + 3, 10 * f + 4, 0);
    check("ovf_set", int'(overflow), 1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 0);
    check("drained", int'(out_valid), 0);
    cycle(0, 0, 0, 1, 0);
    check("ovf_clr", int'(overflow), 0);

    // done_in two cycles into a frame
    cycle(1, 1, 1, 0, 0);
    cycle(0, 2, 1, 0, 0);
    cycle(1, 3, 1, 0, 0);
    check("fe_set", int'(frame_err), 1);
    cycle(0, 4, 1, 0, 0);
    check("busy_end", int'(busy), 0);
    cycle(0, 0, 1, 1, 0);

    // Reset in the third capture cycle, then a clean frame
    cycle(1, 9, 0, 0, 0);
    cycle(0, 8, 0, 0, 0);
    cycle(0, 7, 0, 0, 1);
    check("rst_mid_valid", int'(out_valid), 0);
    frame(-1, -2, -3, -4, 1);
    cycle(0, 0, 1, 0, 0);

    // Full FIFO with the consumer running: no drops
    frame(1, 2, 3, 4, 0);
    frame(5, 6, 7, 8, 0);
    frame(11, 12, 13, 14, 1);
    check("full_pop_ovf", int'(overflow), 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(5) == 0, int'($urandom_range(800)) - 400,
            $urandom_range(9) < 7, $urandom_range(19) == 0,
            $urandom_range(299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
